ctrl_pipe_reg: RTL and testbench

Parametrised pipeline control register for the e5rv32 core, and the successor to the fixed-field, single-stage inter-stage control latches. It carries an arbitrary-width control bundle through DEPTH register stages with a valid bit. It also supports stall (hold), flush (clear), and a programmable post-flush squash window of BUBBLES cycles. Instances sit between pipeline stages (D→E, E→M, M→W) and between the main pipe and the multi-cycle FPU.

---
 rtl/ctrl_pipe_pkg.sv | 24 ++
 rtl/ctrl_pipe_reg_if.sv | 33 +++
 rtl/ctrl_pipe_stage.sv | 52 +++++
 rtl/ctrl_pipe_reg.sv | 99 +++++++++
 tb/tb_ctrl_pipe_reg.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
//   Shared definitions for the pipeline control register family.
//   - cnt_w()    : width of the squash counter for a given BUBBLES value.
//   - ctrl_op_e  : per-edge operation chosen by the priority decode
//                  (reset > clear > squash > stall > load).
package ctrl_pipe_pkg;

  // Counter must hold 0..bubbles; keep at least one bit so BUBBLES=0
  // still yields a legal (always-zero) register.
  function automatic int cnt_w(input int bubbles);
    int w;
    w = $clog2(bubbles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  typedef enum logic [2:0] {
    RST,
    CLR,
    SQUASH,
    HOLD,
    LOAD
  } ctrl_op_e;

endpackage

// File: rtl/ctrl_pipe_reg_if.sv
// ctrl_pipe_reg_if
//   Bundle of the control/data signals of one ctrl_pipe_reg instance.
//   master : the pipeline/hazard logic driving the register.
//   slave  : the ctrl_pipe_reg itself.
//   Signals:
//     stall, clear        hold / flush requests
//     d_valid, d_data     input entry
//     q_valid, q_data     last-stage entry
//     stage_valid         valid bit of every stage (bit 0 = input side)
//     squashing           post-flush squash window active
interface ctrl_pipe_reg_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
);
  logic             stall;
  logic             clear;
  logic             d_valid;
  logic [WIDTH-1:0] d_data;
  logic             q_valid;
  logic [WIDTH-1:0] q_data;
  logic [DEPTH-1:0] stage_valid;
  logic             squashing;

  modport master (
    output stall, clear, d_valid, d_data,
    input  q_valid, q_data, stage_valid, squashing
  );

  modport slave (
    input  stall, clear, d_valid, d_data,
    output q_valid, q_data, stage_valid, squashing
  );
endinterface

// File: rtl/ctrl_pipe_stage.sv
// ctrl_pipe_stage
//   One valid+data register of the control pipeline, updated on the
//   falling edge of clk.
//   Ports:
//     clk        pipeline clock (falling-edge active)
//     bubble     load an invalid entry (valid=0, data=RESET_VAL)
//     hold       keep the current entry
//     in_valid   upstream valid
//     in_data    upstream data
//     out_valid  registered valid
//     out_data   registered data
//   bubble wins over hold. On load, an invalid upstream entry is stored as
//   RESET_VAL so that an invalid stage never carries live control bits.
import ctrl_pipe_pkg::*;

module ctrl_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             bubble,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (bubble) begin
      valid_d = 1'b0;
      data_d  = RESET_VAL;
    end else if (!hold) begin
      valid_d = in_valid;
      data_d  = in_valid ? in_data : RESET_VAL;
    end
  end

  always_ff @(negedge clk) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg
//   Parametrised pipeline control register: carries a WIDTH-bit control
//   bundle with a valid bit through DEPTH falling-edge register stages,
//   with stall (hold), clear (flush) and a BUBBLES-cycle post-flush
//   squash window.
//   Ports:
//     clk    pipeline clock; all state changes on the falling edge
//     reset  synchronous active-low reset, sampled on the falling edge
//     bus    ctrl_pipe_reg_if slave: stall, clear, d_valid, d_data in;
//            q_valid, q_data, stage_valid, squashing out
//   The top owns the squash counter and the priority decode; each stage
//   is a ctrl_pipe_stage instance.
import ctrl_pipe_pkg::*;

module ctrl_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter int               BUBBLES   = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic           clk,
  input  logic           reset,
  ctrl_pipe_reg_if.slave bus
);

  localparam int CW = cnt_w(BUBBLES);

  ctrl_op_e         op;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             flush;
  logic [DEPTH-1:0] valid_w;
  logic [WIDTH-1:0] data_w [DEPTH];

  // Priority: reset > clear > squash > stall > load. During the squash
  // window stall is deliberately ignored so the window length is fixed.
  always_comb begin
    op = LOAD;
    if (!reset) begin
      op = RST;
    end else if (bus.clear) begin
      op = CLR;
    end else if (cnt_q != '0) begin
      op = SQUASH;
    end else if (bus.stall) begin
      op = HOLD;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case (op)
      RST, CLR: cnt_d = CW'(BUBBLES);
      SQUASH:   cnt_d = cnt_q - CW'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  always_ff @(negedge clk) begin
    cnt_q <= cnt_d;
  end

  assign flush = (op == RST) || (op == CLR);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             st_bubble;
    logic             st_in_valid;
    logic [WIDTH-1:0] st_in_data;

    if (gi == 0) begin : g_head
      // Squash only injects at the input side; the rest keeps shifting.
      assign st_bubble   = flush || (op == SQUASH);
      assign st_in_valid = bus.d_valid;
      assign st_in_data  = bus.d_data;
    end else begin : g_body
      assign st_bubble   = flush;
      assign st_in_valid = valid_w[gi-1];
      assign st_in_data  = data_w[gi-1];
    end

    ctrl_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .bubble    (st_bubble),
      .hold      (op == HOLD),
      .in_valid  (st_in_valid),
      .in_data   (st_in_data),
      .out_valid (valid_w[gi]),
      .out_data  (data_w[gi])
    );
  end

  assign bus.q_valid     = valid_w[DEPTH-1];
  assign bus.q_data      = data_w[DEPTH-1];
  assign bus.stage_valid = valid_w;
  assign bus.squashing   = (cnt_q != '0);

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb_ctrl_pipe_reg
//   Directed bench for ctrl_pipe_reg. Four instances with different
//   parameter sets share clk and reset; each directed section drives one
//   instance while the others idle.
//     u_a : DEPTH=2 BUBBLES=0 RESET_VAL=0     reset, latency/throughput
//     u_b : DEPTH=1 BUBBLES=0 RESET_VAL=0     stall
//     u_c : DEPTH=2 BUBBLES=2 RESET_VAL=0     clear/squash interactions
//     u_d : DEPTH=3 BUBBLES=1 RESET_VAL=0x13  reset mid-stream
//   Inputs change 1 time unit after a falling edge; outputs are sampled
//   at that same point, well away from the next falling edge.
`timescale 1ns/1ps

module tb_ctrl_pipe_reg;
  import ctrl_pipe_pkg::*;

  logic clk = 1'b1;
  logic reset = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  ctrl_pipe_reg_if #(.WIDTH(32), .DEPTH(2)) if_a ();
  ctrl_pipe_reg_if #(.WIDTH(32), .DEPTH(1)) if_b ();
  ctrl_pipe_reg_if #(.WIDTH(32), .DEPTH(2)) if_c ();
  ctrl_pipe_reg_if #(.WIDTH(32), .DEPTH(3)) if_d ();

  ctrl_pipe_reg #(.WIDTH(32), .DEPTH(2), .BUBBLES(0), .RESET_VAL(32'h0))
    u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  ctrl_pipe_reg #(.WIDTH(32), .DEPTH(1), .BUBBLES(0), .RESET_VAL(32'h0))
    u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  ctrl_pipe_reg #(.WIDTH(32), .DEPTH(2), .BUBBLES(2), .RESET_VAL(32'h0))
    u_c (.clk(clk), .reset(reset), .bus(if_c.slave));
  ctrl_pipe_reg #(.WIDTH(32), .DEPTH(3), .BUBBLES(1), .RESET_VAL(32'h13))
    u_d (.clk(clk), .reset(reset), .bus(if_d.slave));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    if_a.stall = 0; if_a.clear = 0; if_a.d_valid = 0; if_a.d_data = '0;
    if_b.stall = 0; if_b.clear = 0; if_b.d_valid = 0; if_b.d_data = '0;
    if_c.stall = 0; if_c.clear = 0; if_c.d_valid = 0; if_c.d_data = '0;
    if_d.stall = 0; if_d.clear = 0; if_d.d_valid = 0; if_d.d_data = '0;

    // ---- reset with live-looking input on u_a ----
    #1;
    reset = 1'b0;
    if_a.d_valid = 1; if_a.d_data = 32'hFFFF_FFFF;
    tick(); tick();
    chk("rst_a_q_valid",   32'(if_a.q_valid),     32'h0);
    chk("rst_a_q_data",    if_a.q_data,           32'h0);
    chk("rst_a_stage_vld", 32'(if_a.stage_valid), 32'h0);
    chk("rst_a_squashing", 32'(if_a.squashing),   32'h0);
    chk("rst_c_squashing", 32'(if_c.squashing),   32'h1);
    chk("rst_d_q_data",    if_d.q_data,           32'h13);
    reset = 1'b1;

    // ---- latency / throughput, u_a DEPTH=2 ----
    if_a.d_valid = 1; if_a.d_data = 32'd1;
    tick();
    chk("lat_e1_q_valid",  32'(if_a.q_valid),     32'h0);
    chk("lat_e1_stage_vld",32'(if_a.stage_valid), 32'h1);
    if_a.d_data = 32'd2;
    tick();
    chk("lat_e2_q_valid",  32'(if_a.q_valid),     32'h1);
    chk("lat_e2_q_data",   if_a.q_data,           32'd1);
    if_a.d_data = 32'd3;
    tick();
    chk("lat_e3_q_data",   if_a.q_data,           32'd2);
    if_a.d_valid = 0; if_a.d_data = 32'd5;
    tick();
    chk("lat_e4_q_data",   if_a.q_data,           32'd3);
    chk("lat_e4_stage_vld",32'(if_a.stage_valid), 32'h2);
    tick();
    chk("lat_e5_q_valid",  32'(if_a.q_valid),     32'h0);
    chk("lat_e5_q_data",   if_a.q_data,           32'h0);

    // ---- stall, u_b DEPTH=1 ----
    if_b.d_valid = 1; if_b.d_data = 32'hA5;
    tick();
    chk("stl_load_q_data", if_b.q_data,           32'hA5);
    if_b.stall = 1; if_b.d_data = 32'h5A;
    tick();
    chk("stl_h1_q_data",   if_b.q_data,           32'hA5);
    tick();
    chk("stl_h2_q_data",   if_b.q_data,           32'hA5);
    tick();
    chk("stl_h3_q_data",   if_b.q_data,           32'hA5);
    chk("stl_h3_q_valid",  32'(if_b.q_valid),     32'h1);
    if_b.stall = 0;
    tick();
    chk("stl_rel_q_data",  if_b.q_data,           32'h5A);

    // ---- clear + squash, u_c DEPTH=2 BUBBLES=2 ----
    chk("sq_idle_squash",  32'(if_c.squashing),   32'h0);
    if_c.d_valid = 1; if_c.d_data = 32'h10;
    tick();
    if_c.d_data = 32'h11;
    tick();
    chk("sq_pre_q_data",   if_c.q_data,           32'h10);
    // clear edge n, together with stall: flush must win
    if_c.clear = 1; if_c.stall = 1; if_c.d_data = 32'h12;
    tick();
    chk("sq_n_q_valid",    32'(if_c.q_valid),     32'h0);
    chk("sq_n_stage_vld",  32'(if_c.stage_valid), 32'h0);
    chk("sq_n_q_data",     if_c.q_data,           32'h0);
    chk("sq_n_squashing",  32'(if_c.squashing),   32'h1);
    if_c.clear = 0; if_c.stall = 0; if_c.d_data = 32'h13;
    tick();   // n+1: squash, input dropped
    chk("sq_n1_squashing", 32'(if_c.squashing),   32'h1);
    chk("sq_n1_stage_vld", 32'(if_c.stage_valid), 32'h0);
    if_c.stall = 1; if_c.d_data = 32'h14;
    tick();   // n+2: stall ignored, counter still decrements
    chk("sq_n2_squashing", 32'(if_c.squashing),   32'h0);
    chk("sq_n2_stage_vld", 32'(if_c.stage_valid), 32'h0);
    if_c.stall = 0; if_c.d_data = 32'h15;
    tick();   // n+3: first accepted input
    chk("sq_n3_stage_vld", 32'(if_c.stage_valid), 32'h1);
    if_c.d_valid = 0;
    tick();
    chk("sq_n4_q_data",    if_c.q_data,           32'h15);
    chk("sq_n4_q_valid",   32'(if_c.q_valid),     32'h1);

    // clear while squashing (counter=1) reloads the counter
    if_c.clear = 1;
    tick();   // counter 2
    if_c.clear = 0;
    tick();   // counter 1
    chk("rl_c1_squashing", 32'(if_c.squashing),   32'h1);
    if_c.clear = 1;
    tick();   // reload to 2
    if_c.clear = 0;
    tick();   // counter 1
    chk("rl_after_squash", 32'(if_c.squashing),   32'h1);
    tick();   // counter 0
    chk("rl_end_squash",   32'(if_c.squashing),   32'h0);

    // ---- reset mid-stream, u_d DEPTH=3 RESET_VAL=0x13 ----
    if_d.d_valid = 1; if_d.d_data = 32'h21;
    tick();
    if_d.d_data = 32'h22;
    tick();
    if_d.d_data = 32'h23;
    tick();
    chk("mid_full_stg_vld",32'(if_d.stage_valid), 32'h7);
    chk("mid_full_q_data", if_d.q_data,           32'h21);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_stg_vld", 32'(if_d.stage_valid), 32'h0);
    chk("mid_rst_q_data",  if_d.q_data,           32'h13);
    chk("mid_rst_q_valid", 32'(if_d.q_valid),     32'h0);
    chk("mid_rst_squash",  32'(if_d.squashing),   32'h1);
    // invalid input still lands as RESET_VAL, not the presented data
    if_d.d_valid = 0; if_d.d_data = 32'hFF;
    tick(); tick(); tick(); tick();
    chk("mid_bub_q_data",  if_d.q_data,           32'h13);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
